// File: rtl/align_pipe.sv
// Two-stage leading-one aligner: normalises b so its leading 1 sits at a's leading-1 position.
// Optional sticky output (bits dropped by the right shift) enabled by ALIGN_PIPE_STICKY_EN.
module align_pipe #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [SHW-1:0]   shamt,
  output logic             a_zero,
  output logic             b_zero
`ifdef ALIGN_PIPE_STICKY_EN
  ,
  output logic             sticky
`endif
);

  localparam int LZW = $clog2(WIDTH);

  // Zero input yields 0; callers qualify it with the zero flag.
  function automatic logic [LZW-1:0] lzc(input logic [WIDTH-1:0] x);
    logic [LZW-1:0] n;
    logic           found;
    n     = {LZW{1'b0}};
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = LZW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [LZW-1:0]   s1_lza_r;
  logic [LZW-1:0]   s1_lzb_r;
  logic             s1_azero_r;
  logic             s1_bzero_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic [SHW-1:0]   shamt_r;
  logic             a_zero_r;
  logic             b_zero_r;
  logic             sticky_r;

  logic             s1_adv_s;
  logic             s2_drain_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] norm_s;
  logic [WIDTH-1:0] aligned_s;
  logic [SHW-1:0]   shamt_s;
  logic             sticky_s;

  // Handshake: the only combinational output path is out_ready -> in_ready.
  always_comb begin
    s2_drain_s = out_valid_r && out_ready;
    s1_adv_s   = s1_valid_r && (!out_valid_r || out_ready);
    in_ready_s = !reset && !flush && (!s1_valid_r || s1_adv_s);
    accept_s   = in_valid && in_ready_s;
  end

  // Stage-2 datapath: normalise b, then shift right to a's leading-one position.
  always_comb begin
    norm_s    = s1_b_r << s1_lzb_r;
    aligned_s = {WIDTH{1'b0}};
    shamt_s   = {SHW{1'b0}};
    sticky_s  = 1'b0;
    if (s1_bzero_r) begin
      aligned_s = {WIDTH{1'b0}};
      shamt_s   = {SHW{1'b0}};
      sticky_s  = 1'b0;
    end else begin
      aligned_s = norm_s >> s1_lza_r;
      shamt_s   = {1'b0, s1_lzb_r} - {1'b0, s1_lza_r};
      sticky_s  = |(norm_s & ~({WIDTH{1'b1}} << s1_lza_r));
    end
  end

  // Stage 1: capture b and both leading-zero counts on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_b_r     <= {WIDTH{1'b0}};
      s1_lza_r   <= {LZW{1'b0}};
      s1_lzb_r   <= {LZW{1'b0}};
      s1_azero_r <= 1'b0;
      s1_bzero_r <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_b_r     <= b;
      s1_lza_r   <= lzc(a);
      s1_lzb_r   <= lzc(b);
      s1_azero_r <= (a == {WIDTH{1'b0}});
      s1_bzero_r <= (b == {WIDTH{1'b0}});
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: result registers only load on advance, so they stay bit-stable under stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_r       <= {WIDTH{1'b0}};
      shamt_r     <= {SHW{1'b0}};
      a_zero_r    <= 1'b0;
      b_zero_r    <= 1'b0;
      sticky_r    <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      out_valid_r <= 1'b1;
      out_r       <= aligned_s;
      shamt_r     <= shamt_s;
      a_zero_r    <= s1_azero_r;
      b_zero_r    <= s1_bzero_r;
      sticky_r    <= sticky_s;
    end else if (s2_drain_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign shamt     = shamt_r;
  assign a_zero    = a_zero_r;
  assign b_zero    = b_zero_r;
`ifdef ALIGN_PIPE_STICKY_EN
  assign sticky    = sticky_r;
`else
  logic unused_sticky_s;
  assign unused_sticky_s = sticky_r;
`endif

endmodule

// File: tb/tb_align_pipe.sv
// Randomised self-checking bench for align_pipe with a queue-based reference model.
module tb_align_pipe;

  localparam int WIDTH = 32;
  localparam int SHW   = 6;

  logic             clock;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [SHW-1:0]   shamt;
  logic             a_zero;
  logic             b_zero;
  logic             sticky;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  op_t q[$];

  align_pipe #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .shamt     (shamt),
    .a_zero    (a_zero),
    .b_zero    (b_zero)
`ifdef ALIGN_PIPE_STICKY_EN
    ,
    .sticky    (sticky)
`endif
  );

`ifndef ALIGN_PIPE_STICKY_EN
  assign sticky = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: leading zeros via log2 by repeated halving, shifts as multiply/divide by powers of two.
  function automatic int lead_zeros(input logic [WIDTH-1:0] x);
    longint unsigned v;
    int p;
    v = x;
    p = 0;
    if (x == 0) return 0;
    while (v > 1) begin
      v = v / 2;
      p++;
    end
    return WIDTH - 1 - p;
  endfunction

  task automatic ref_model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           output logic [WIDTH-1:0] o, output int sh,
                           output bit az, output bit bz, output bit st);
    int lza, lzb;
    longint unsigned norm, pa;
    lza = lead_zeros(av);
    lzb = lead_zeros(bv);
    az  = (av == 0);
    bz  = (bv == 0);
    if (bz) begin
      o = 0; sh = 0; st = 0;
    end else begin
      norm = longint'(bv) * (64'd1 << lzb);
      pa   = 64'd1 << lza;
      o    = WIDTH'(norm / pa);
      st   = (norm % pa) != 0;
      sh   = lzb - lza;
    end
  endtask

  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_out;
  logic [SHW-1:0]   held_shamt;
  logic             held_az, held_bz, held_st;

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clock) begin
    op_t it;
    logic [WIDTH-1:0] eo;
    int esh;
    bit eaz, ebz, est;
    if (reset) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_val("stall_valid", 64'(out_valid), 64'd1);
        check_val("stall_out", 64'(out), 64'(held_out));
        check_val("stall_shamt", 64'(shamt), 64'(held_shamt));
        check_val("stall_flags", {61'd0, a_zero, b_zero, sticky}, {61'd0, held_az, held_bz, held_st});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_val("spurious_out", 64'd1, 64'd0);
        end else begin
          it = q.pop_front();
          ref_model(it.a, it.b, eo, esh, eaz, ebz, est);
          check_val("sb_out", 64'(out), 64'(eo));
          check_val("sb_shamt", 64'(longint'($signed(shamt))), 64'(longint'(esh)));
          check_val("sb_zero", {62'd0, a_zero, b_zero}, {62'd0, eaz, ebz});
`ifdef ALIGN_PIPE_STICKY_EN
          check_val("sb_sticky", 64'(sticky), 64'(est));
`endif
        end
      end
      if (flush) q.delete();
      if (in_valid && in_ready) q.push_back('{a: a, b: b});
      stall_prev = out_valid && !out_ready && !flush;
      held_out   = out;
      held_shamt = shamt;
      held_az    = a_zero;
      held_bz    = b_zero;
      held_st    = sticky;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] shaped();
    int r;
    r = $urandom_range(0, 11);
    if (r == 0) return 0;
    if (r == 1) return 1;
    if (r == 2) return 32'h8000_0000;
    return $urandom >> $urandom_range(0, 31);
  endfunction

  // Issue one op into an empty pipe and check latency and result directly.
  task automatic send_one(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] eo, input int esh,
                          input bit eaz, input bit ebz, input bit est);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    check_val("issue_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_val("lat1_valid", 64'(out_valid), 64'd0);
    step();
    check_val("lat2_valid", 64'(out_valid), 64'd1);
    check_val("dir_out", 64'(out), 64'(eo));
    check_val("dir_shamt", 64'(longint'($signed(shamt))), 64'(longint'(esh)));
    check_val("dir_zero", {62'd0, a_zero, b_zero}, {62'd0, eaz, ebz});
`ifdef ALIGN_PIPE_STICKY_EN
    check_val("dir_sticky", 64'(sticky), 64'(est));
`endif
    step();
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, eo;
    int esh;
    bit eaz, ebz, est;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h0000_00ff; b = 32'h0000_0011;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_out", 64'(out), 64'd0);
      check_val("rst_shamt", 64'(shamt), 64'd0);
      check_val("rst_ready", 64'(in_ready), 64'd0);
    end
    reset = 1'b0; in_valid = 1'b0;
    step();
    check_val("post_rst_ready", 64'(in_ready), 64'd1);
    check_val("post_rst_valid", 64'(out_valid), 64'd0);

    send_one(32'h0000_0100, 32'h0000_0003, 32'h0000_0180, 7, 1'b0, 1'b0, 1'b0);
    send_one(32'h0000_0001, 32'h8000_0001, 32'h0000_0001, -31, 1'b0, 1'b0, 1'b1);
    send_one(32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b1, 1'b0);
    send_one(32'h0000_0000, 32'h0000_0010, 32'h8000_0000, 27, 1'b1, 1'b0, 1'b0);

    // Streaming: four results on consecutive cycles.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = shaped(); b = shaped(); in_valid = 1'b1;
      step();
      if (i >= 1) check_val("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check_val("stream_last", 64'(out_valid), 64'd1);
    step();
    check_val("stream_done", 64'(out_valid), 64'd0);

    // Stall with both stages full.
    out_ready = 1'b0;
    a = shaped(); b = shaped(); in_valid = 1'b1;
    step();
    check_val("stall_ready1", 64'(in_ready), 64'd1);
    a = shaped(); b = shaped();
    step();
    check_val("stall_ready2", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (3) step();
    check_val("stall_drained", 64'(out_valid), 64'd0);

    // Flush with two ops in flight.
    out_ready = 1'b0;
    a = shaped(); b = shaped(); in_valid = 1'b1;
    step();
    a = shaped(); b = shaped();
    step();
    flush = 1'b1; a = shaped(); b = shaped();
    check_val("flush_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    check_val("flush_gone", 64'(out_valid), 64'd0);
    ra = shaped(); rb = shaped();
    ref_model(ra, rb, eo, esh, eaz, ebz, est);
    send_one(ra, rb, eo, esh, eaz, ebz, est);

    // Random traffic with back-pressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      a = shaped(); b = shaped();
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) step();
    check_val("drain_empty", 64'(q.size()), 64'd0);
    check_val("drain_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/align_pipe.md
Name: align_pipe

Overview:
- Pipelined, parametrised leading-one aligner for the iterative divider front end.
- Takes divisor B and dividend A and normalises B so its leading 1 sits at A's leading-1 position.
- Returns a signed shift amount, so B > A is handled (result can be negative).
- Two registered stages with valid/ready handshake and flush; full throughput of one operand pair per cycle.

Parameters:
- WIDTH, 32, operand width; power of two, >= 4.
- SHW, $clog2(WIDTH)+1, width of signed shift amount (localparam, derived, not overridable).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline clear; drops in-flight ops
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts pair this cycle
- a  input  WIDTH  reference operand (dividend), unsigned
- b  input  WIDTH  operand to align (divisor), unsigned
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  aligned B
- shamt  output  SHW  signed two's complement lzB - lzA
- a_zero  output  1  A was zero
- b_zero  output  1  B was zero

Behaviour:
- Reset: all outputs 0 and both stage valids 0; in_ready = 0 during reset, 1 the cycle after.
- Reset mid-operation discards all in-flight data.
- lzX = count of leading zeros of X over WIDTH bits (0..WIDTH-1); zero operand handling below.
- Stage 1 registers a, b, lzA, lzB and the zero flags on accept (in_valid && in_ready).
- Stage 2 registers:
  - out = (b << lzB) >> lzA, logical right shift, zero fill.
  - shamt = lzB - lzA, sign-extended to SHW.
- Special cases:
  - B == 0: out = 0, shamt = 0, b_zero = 1.
  - A == 0 and B != 0: treat lzA = 0; out = B normalised to bit WIDTH-1; shamt = lzB; a_zero = 1.
- Latency: accept at cycle N gives out_valid at N+2 when there is no stall.
- Stage advance: each stage loads when its downstream slot is empty or draining this cycle.
  - in_ready = !s1_valid || (s1 advancing).
  - s2 drains when out_valid && out_ready.
- Stall: out_valid && !out_ready holds out, shamt and flags bit-stable; both stages can be full; in_ready deasserts when s1 and s2 are both full and s2 is not draining.
- Back-to-back: with out_ready held 1, one result per cycle, no bubbles.
- flush:
  - Clears both stage valids next edge; data registers are don't-care.
  - in_ready = 0 while flush is high, so a simultaneous in_valid is not accepted.
  - A result with out_valid && out_ready in the flush cycle counts as delivered.
- No combinational path from in_valid/a/b to outputs. The only combinational output path is out_ready -> in_ready.

Optional Feature:
- Macro ALIGN_PIPE_STICKY_EN.
- Defined:
  - Extra output sticky (1 bit, reset 0, registered alongside out).
  - sticky = OR of bits of (b << lzB) dropped by the right shift by lzA.
  - Held stable during stall; 0 when b_zero.
- Undefined: port absent, no sticky logic; all other behaviour identical.

Test Plan:
- Reset held 3 cycles with in_valid=1 -> out_valid=0, out=0, shamt=0, no accept; in_ready=1 the cycle after reset drops.
- a=0x00000100, b=0x00000003, out_ready=1 -> two cycles later: out=0x00000180, shamt=+7, a_zero=b_zero=0.
- a=0x00000001, b=0x80000001 -> out=0x00000001, shamt=-31 (SHW=6: 6'b100001); sticky=1 when ALIGN_PIPE_STICKY_EN is defined, otherwise port absent.
- b=0, a=0x1234 -> out=0, shamt=0, b_zero=1; separately a=0, b=0x00000010 -> out=0x80000000, shamt=+27, a_zero=1.
- Stream 4 pairs with out_ready=1 -> 4 results on consecutive cycles. Then out_ready=0 for 5 cycles -> out stable, in_ready=0 after two more accepts; release -> order preserved, no loss or duplication.
- Two ops in flight, assert flush with in_valid=1 -> out_valid=0 next cycle, flushed ops never appear, flush-cycle input not accepted; a new op issued after flush returns correctly 2 cycles later.
